// File: rtl/mac_mul_pipe.sv
// mac_mul_pipe: pipelined lane-packed multiplier feeding the MAC accumulator.
// Computes A (1..LANES lanes of MIN_WIDTH bits) times B, unsigned or signed.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   in_valid/ready input handshake; in_a, in_b, in_cfg captured together
//   in_cfg         [1:0] mode m (2^m active lanes), [2] signed enable
//   out_valid/ready output handshake; out_data product, out_err bad mode
//   busy           high while any transaction is in flight
module mac_mul_pipe #(
  parameter int MIN_WIDTH = 8,
  parameter int LANES     = 4,
  parameter int LATENCY   = 2,
  parameter int INT_WIDTH = (LANES + 1) * MIN_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*MIN_WIDTH-1:0]   in_a,
  input  logic [MIN_WIDTH-1:0]         in_b,
  input  logic [2:0]                   in_cfg,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INT_WIDTH-1:0]         out_data,
  output logic                         out_err,
  output logic                         busy
);

  localparam int W  = MIN_WIDTH;
  // Headroom so every shifted partial product is formed without
  // truncating its sign extension; only the low INT_WIDTH bits are kept.
  localparam int XW = INT_WIDTH + W + 2;

  logic                 adv;
  logic [LATENCY-1:0]   vld;
  logic                 illegal;
  logic [INT_WIDTH-1:0] pp_in  [LANES];
  logic [INT_WIDTH-1:0] fin_pp [LANES];
  logic                 fin_err;
  logic                 fin_vld;
  logic [INT_WIDTH-1:0] fin_sum;

  // Single global stall: every stage holds while the output is blocked.
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;
  assign out_valid = vld[LATENCY-1];
  assign busy      = |vld;

  // Each lane is widened to W+1 bits; only the top active lane carries the
  // sign in signed mode, the lower lanes are magnitude digits.
  always_comb begin : pp_gen
    int                    nact;
    logic                  sgn;
    logic signed [W:0]     ea;
    logic signed [W:0]     eb;
    logic signed [2*W+1:0] prod;
    logic [XW-1:0]         wide;
    nact    = 32'd1 << in_cfg[1:0];
    sgn     = in_cfg[2];
    illegal = nact > LANES;
    eb      = $signed({sgn & in_b[W-1], in_b});
    ea      = '0;
    prod    = '0;
    wide    = '0;
    for (int k = 0; k < LANES; k++) begin
      ea   = $signed({sgn && (k == nact - 1) && in_a[k*W+W-1],
                      in_a[k*W +: W]});
      prod = ea * eb;
      wide = {{(XW-2*W-2){prod[2*W+1]}}, prod} << (k * W);
      if (k < nact && !illegal) pp_in[k] = wide[INT_WIDTH-1:0];
      else                      pp_in[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int s = 1; s < LATENCY; s++) vld[s] <= vld[s-1];
    end
  end

  if (LATENCY == 1) begin : g_direct
    always_comb begin
      fin_pp  = pp_in;
      fin_err = illegal;
      fin_vld = in_valid;
    end
  end else begin : g_staged
    logic [INT_WIDTH-1:0] pp_r  [LATENCY-1][LANES];
    logic                 err_r [LATENCY-1];

    always_ff @(posedge clk) begin
      if (adv) begin
        pp_r[0]  <= pp_in;
        err_r[0] <= illegal;
        for (int s = 1; s < LATENCY - 1; s++) begin
          pp_r[s]  <= pp_r[s-1];
          err_r[s] <= err_r[s-1];
        end
      end
    end

    always_comb begin
      fin_pp  = pp_r[LATENCY-2];
      fin_err = err_r[LATENCY-2];
      fin_vld = vld[LATENCY-2];
    end
  end

  always_comb begin
    fin_sum = '0;
    for (int k = 0; k < LANES; k++) fin_sum = fin_sum + fin_pp[k];
  end

  // Output registers load only real transactions so data stays put
  // across bubbles as well as stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (adv && fin_vld) begin
      out_data <= fin_err ? '0 : fin_sum;
      out_err  <= fin_err;
    end
  end

endmodule

// File: tb/tb_mac_mul_pipe.sv
// tb_mac_mul_pipe: directed self-checking bench for mac_mul_pipe
// (W=8, LANES=4, LATENCY=2).
module tb_mac_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [7:0]  in_b;
  logic [2:0]  in_cfg;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_data;
  logic        out_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  mac_mul_pipe #(
    .MIN_WIDTH(8),
    .LANES(4),
    .LATENCY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_cfg(in_cfg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One isolated transaction: result must show up 2 edges after accept.
  task automatic one(input string       tag,
                     input logic [31:0] a,
                     input logic [7:0]  b,
                     input logic [2:0]  cfg,
                     input logic [39:0] exp,
                     input logic        eerr);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cfg   = cfg;
    #1 check({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_err"}, out_err, eerr);
  endtask

  logic [31:0] bp_a [5] = '{32'h0000_0002, 32'h0000_0100, 32'h0100_0000,
                            32'h0000_00FF, 32'h0000_7FFF};
  logic [7:0]  bp_b [5] = '{8'h03, 8'h10, 8'h02, 8'hFF, 8'h80};
  logic [2:0]  bp_c [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [39:0] bp_e [5] = '{40'h00_0000_0006, 40'h00_0000_1000,
                            40'h00_0200_0000, 40'h00_0000_0001,
                            40'hFF_FFC0_0080};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   got;
    logic held;
    logic fire;
    logic [39:0] hd;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cfg    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vld", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_err", out_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1 check("rst_rdy", in_ready, 1);

    one("u1", 32'h0000_00FF, 8'hFF, 3'b000, 40'h00_0000_FE01, 1'b0);
    one("u2", 32'hABAB_1234, 8'h56, 3'b001, 40'h00_0006_1D78, 1'b0);
    one("u4", 32'hFFFF_FFFF, 8'hFF, 3'b010, 40'hFE_FFFF_FF01, 1'b0);
    one("s4", 32'hFFFF_FFFF, 8'hFF, 3'b110, 40'h00_0000_0001, 1'b0);
    one("s1", 32'h1234_5680, 8'h02, 3'b100, 40'hFF_FFFF_FF00, 1'b0);
    one("bad", 32'h1234_5678, 8'h9A, 3'b011, 40'h00_0000_0000, 1'b1);
    one("s2", 32'h0000_FFFE, 8'h03, 3'b101, 40'hFF_FFFF_FFFA, 1'b0);

    // Backpressure: five back-to-back, out_ready low in cycles 3..8.
    idx  = 0;
    got  = 0;
    held = 1'b0;
    hd   = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 8);
      in_valid  = idx < 5;
      if (idx < 5) begin
        in_a   = bp_a[idx];
        in_b   = bp_b[idx];
        in_cfg = bp_c[idx];
      end
      #1;
      if (out_valid && !out_ready) begin
        check("bp_inrdy", in_ready, 0);
        if (held) check("bp_hold", out_data, hd);
        held = 1'b1;
        hd   = out_data;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_res%0d", got), out_data, bp_e[got]);
        got++;
      end
      fire = in_valid && in_ready;
      @(posedge clk);
      if (fire) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got, 5);
    @(negedge clk);
    check("bp_busy", busy, 0);
    check("bp_vld", out_valid, 0);

    // Reset with two transactions in flight.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'h0000_0011;
    in_b     = 8'h02;
    in_cfg   = 3'b000;
    @(posedge clk);
    @(negedge clk);
    in_a = 32'h0000_0022;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_vld", out_valid, 0);
    check("mid_busy0", busy, 0);
    check("mid_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("mid_rdy", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_stale", out_valid, 0);
    end
    one("post", 32'h0000_0003, 8'h05, 3'b000, 40'h00_0000_000F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
